// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// The optional in-place accumulation build is enabled with BOOTH_MUL_ACC_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radix-4 Booth codes taken from {b[2i+1], b[2i], b[2i-1]}.
  localparam logic [2:0] BOOTH_Z_POS = 3'b000;
  localparam logic [2:0] BOOTH_P1_A  = 3'b001;
  localparam logic [2:0] BOOTH_P1_B  = 3'b010;
  localparam logic [2:0] BOOTH_P2    = 3'b011;
  localparam logic [2:0] BOOTH_M2    = 3'b100;
  localparam logic [2:0] BOOTH_M1_A  = 3'b101;
  localparam logic [2:0] BOOTH_M1_B  = 3'b110;
  localparam logic [2:0] BOOTH_Z_NEG = 3'b111;

  function automatic int booth_iter(input int data_w);
    return data_w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Combinational radix-4 Booth digit decoder: 3-bit code to magnitude/sign selects.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] code,
  output logic       sel_zero,
  output logic       sel_one,
  output logic       sel_two,
  output logic       sel_sub
);

  always_comb begin
    sel_zero = 1'b0;
    sel_one  = 1'b0;
    sel_two  = 1'b0;
    case (code)
      BOOTH_Z_POS, BOOTH_Z_NEG:                       sel_zero = 1'b1;
      BOOTH_P1_A, BOOTH_P1_B, BOOTH_M1_A, BOOTH_M1_B: sel_one  = 1'b1;
      BOOTH_P2, BOOTH_M2:                             sel_two  = 1'b1;
    endcase
  end

  assign sel_sub = code[2];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier retiring one digit per clock, signed or unsigned.
// Define BOOTH_MUL_ACC_EN to add in_acc, which adds each product onto the previous result.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     op2,
  input  logic                  op_signed,
`ifdef BOOTH_MUL_ACC_EN
  input  logic                  in_acc,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   dout_C,
  output logic                  busy
);

  localparam int ITER = booth_iter(DATA_W);
  localparam int AW   = 2 * DATA_W + 2;
  localparam int MW   = DATA_W + 3;
  localparam int CW   = $clog2(ITER);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         mcand_q, mcand_d;
  logic [MW-1:0]         mult_q, mult_d;
  logic [2*DATA_W-1:0]   res_q, res_d;
  logic                  accsel_q, accsel_d;

  logic                  sel_zero, sel_one, sel_two, sel_sub;
  logic [AW-1:0]         pp_mag, pp;
  logic [2*DATA_W-1:0]   res_base;
  logic                  acc_req;

`ifdef BOOTH_MUL_ACC_EN
  assign acc_req = in_acc;
`else
  assign acc_req = 1'b0;
`endif

  // The multiplier shifts right two bits per digit, so bits [2:0] are always the current code.
  booth_enc u_enc (
    .code     (mult_q[2:0]),
    .sel_zero (sel_zero),
    .sel_one  (sel_one),
    .sel_two  (sel_two),
    .sel_sub  (sel_sub)
  );

  assign pp_mag   = sel_zero ? '0 : (sel_two ? (mcand_q << 1) : (sel_one ? mcand_q : '0));
  assign pp       = sel_sub ? (~pp_mag + AW'(1)) : pp_mag;
  assign res_base = accsel_q ? res_q : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    res_d    = res_q;
    accsel_d = accsel_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = CALC;
          cnt_d    = '0;
          acc_d    = '0;
          accsel_d = acc_req;
          mcand_d  = op_signed ? {{(AW-DATA_W){op1[DATA_W-1]}}, op1}
                               : {{(AW-DATA_W){1'b0}}, op1};
          mult_d   = op_signed ? {{2{op2[DATA_W-1]}}, op2, 1'b0}
                               : {2'b00, op2, 1'b0};
        end
      end
      CALC: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        mult_d  = mult_q >> 2;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
          res_d   = acc_d[2*DATA_W-1:0] + res_base;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mult_q   <= '0;
      res_q    <= '0;
      accsel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      res_q    <= res_d;
      accsel_q <= accsel_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dout_C    = res_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed corner cases plus a random sweep.
// Expected products come from plain integer multiplication of the extended operands.
module tb_booth_mul_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic           op_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] dout_C;
  logic           busy;
`ifdef BOOTH_MUL_ACC_EN
  logic           in_acc = 1'b0;
`endif

  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] prevRes = '0;
  bit             randMode = 1'b0;
  bit             readyVal = 1'b1;

  always #5 clk = ~clk;

  booth_mul_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .op_signed (op_signed),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_C    (dout_C),
    .busy      (busy)
  );

  always @(posedge clk) begin
    #1;
    out_ready = randMode ? 1'($urandom_range(0, 1)) : readyVal;
  end

  task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit s, input bit acc, input logic [2*W-1:0] prev);
    longint x, y, pr;
    logic [2*W-1:0] p;
    x  = s ? longint'($signed(a)) : longint'(a);
    y  = s ? longint'($signed(b)) : longint'(b);
    pr = x * y;
    p  = pr[2*W-1:0];
    if (acc) p = p + prev;
    return p;
  endfunction

  // Monitor: a handshake completes at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spurious_out_valid: got dout_C %h with no accepted operation", dout_C);
      end else begin
        checkOutput("product", dout_C, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit acc);
    bit accepted;
    bit useAcc;
    accepted = 1'b0;
    useAcc   = 1'b0;
    @(negedge clk);
    op1       = a;
    op2       = b;
    op_signed = s;
    in_valid  = 1'b1;
`ifdef BOOTH_MUL_ACC_EN
    in_acc = acc;
    useAcc = acc;
`endif
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (in_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (accepted) begin
      prevRes = refProduct(a, b, s, useAcc, prevRes);
      expQ.push_back(prevRes);
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready got %b expected 1", in_ready);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = (expQ.size() == 0) && in_ready;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending results got %0d expected 0", expQ.size());
    end
  endtask

  initial begin
    bit gotValid;
    #12;
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_dout_C", dout_C, 16'h0000);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // -128 x -128 with latency check
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("calc_busy", 16'(busy), 16'd1);
    checkOutput("calc_in_ready", 16'(in_ready), 16'd0);
    repeat (4) @(negedge clk);
    checkOutput("latency_early", 16'(out_valid), 16'd0);
    @(negedge clk);
    checkOutput("latency_valid", 16'(out_valid), 16'd1);
    checkOutput("neg128_sq", dout_C, 16'h4000);
    waitIdle();

    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
    waitIdle();
    checkOutput("unsigned_ff_ff", dout_C, 16'hFE01);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    waitIdle();
    checkOutput("signed_ff_ff", dout_C, 16'h0001);

    // Result must hold while the consumer stalls, and new operands must be ignored
    readyVal = 1'b0;
    @(negedge clk);
    applyStimulus(8'h7F, 8'hFF, 1'b1, 1'b0);
    gotValid = 1'b0;
    for (int i = 0; i < 50 && !gotValid; i++) begin
      @(negedge clk);
      gotValid = out_valid;
    end
    checkOutput("hold_valid_seen", 16'(gotValid), 16'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op1 = 8'($urandom);
      op2 = 8'($urandom);
      checkOutput("hold_dout_C", dout_C, 16'hFF81);
      checkOutput("hold_in_ready", 16'(in_ready), 16'd0);
      checkOutput("hold_out_valid", 16'(out_valid), 16'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    readyVal = 1'b1;
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("no_extra_valid", 16'(out_valid), 16'd0);

    // Reset two cycles into CALC
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midreset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("midreset_busy", 16'(busy), 16'd0);
    checkOutput("midreset_dout_C", dout_C, 16'h0000);
    void'(expQ.pop_back());
    prevRes = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd3, 8'd5, 1'b0, 1'b0);
    waitIdle();
    checkOutput("after_reset_3x5", dout_C, 16'h000F);

`ifdef BOOTH_MUL_ACC_EN
    applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
    waitIdle();
    checkOutput("acc_3x4", dout_C, 16'd12);
    applyStimulus(8'd5, 8'd6, 1'b0, 1'b1);
    waitIdle();
    checkOutput("acc_5x6_plus", dout_C, 16'd42);
    applyStimulus(8'd2, 8'd2, 1'b0, 1'b0);
    waitIdle();
    checkOutput("acc_2x2", dout_C, 16'd4);
`endif

    randMode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    waitIdle();
    randMode = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("final_idle", 16'(out_valid), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
